// File: rtl/aes_pkg.sv
// Shared AES constants, the forward and inverse S-box tables, and the state byte-index helper.
// The inverse table is derived from the forward one at elaboration time, so the two cannot disagree.
package aes_pkg;

  localparam int unsigned AES_STATE_W = 128;
  localparam int unsigned AES_NB      = 4;
  localparam int unsigned AES_BYTE_W  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sub_shift_state_t;

  // Byte x of the table sits at bits [2047-8x -: 8], i.e. [~{x,3'b000} -: 8].
  localparam logic [2047:0] SBOX_FWD_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [2047:0] build_inv_table();
    logic [2047:0] t;
    logic [7:0]    b;
    logic [7:0]    v;
    t = '0;
    for (int unsigned i = 0; i < 256; i++) begin
      b = 8'(i);
      v = SBOX_FWD_TABLE[~{b, 3'b000} -: 8];
      t[~{v, 3'b000} -: 8] = b;
    end
    return t;
  endfunction

  localparam logic [2047:0] SBOX_INV_TABLE = build_inv_table();

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    return SBOX_FWD_TABLE[~{x, 3'b000} -: 8];
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] x);
    return SBOX_INV_TABLE[~{x, 3'b000} -: 8];
  endfunction

  // MSB position of byte (row, col); use as vec[byte_msb(r, c) -: AES_BYTE_W].
  function automatic int unsigned byte_msb(input int unsigned row, input int unsigned col);
    return AES_STATE_W - 1 - AES_BYTE_W * (AES_NB * col + row);
  endfunction

endpackage

// File: rtl/sub_shift_if.sv
// Start/ready handshake and data bus of the SubBytes+ShiftRows stage.
interface sub_shift_if;
  import aes_pkg::*;

  logic                   start_i;
  logic                   decrypt_i;
  logic [AES_STATE_W-1:0] data_i;
  logic [AES_STATE_W-1:0] data_o;
  logic                   ready_o;
  logic                   busy_o;

  modport master (
    output start_i, decrypt_i, data_i,
    input  data_o, ready_o, busy_o
  );

  modport slave (
    input  start_i, decrypt_i, data_i,
    output data_o, ready_o, busy_o
  );

endinterface

// File: rtl/aes_sbox.sv
// Single combinational S-box lane; inv selects the inverse table.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  input  logic       inv,
  output logic [7:0] out_byte
);

  assign out_byte = inv ? sbox_inv(in_byte) : sbox_fwd(in_byte);

endmodule

// File: rtl/sub_shift.sv
// AES SubBytes+ShiftRows stage: 4 shared S-box lanes, one column per cycle.
// Defining SUB_SHIFT_PARALLEL_EN builds 16 lanes and finishes the whole state in one cycle.
module sub_shift
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  sub_shift_if.slave bus
);

  localparam int unsigned NB     = AES_NB;
  localparam int unsigned BYTE_W = AES_BYTE_W;
  localparam int unsigned COL_W  = NB * BYTE_W;

  sub_shift_state_t       fsm;
  logic [AES_STATE_W-1:0] shifted;
  logic [AES_STATE_W-1:0] data_q;
  logic                   ready_q;
  logic                   busy_q;

  // Row permutation is applied on capture; S-box and shift commute, so the lanes see shifted bytes.
  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < NB; r++) begin : g_row
      assign shifted[byte_msb(r, c) -: BYTE_W] = bus.decrypt_i
        ? bus.data_i[byte_msb(r, (c + NB - r) % NB) -: BYTE_W]
        : bus.data_i[byte_msb(r, (c + r) % NB) -: BYTE_W];
    end
  end

`ifdef SUB_SHIFT_PARALLEL_EN

  logic [AES_STATE_W-1:0] sub_all;

  for (genvar k = 0; k < NB * NB; k++) begin : g_lane
    aes_sbox u_sbox (
      .in_byte  (shifted[AES_STATE_W - 1 - BYTE_W * k -: BYTE_W]),
      .inv      (bus.decrypt_i),
      .out_byte (sub_all[AES_STATE_W - 1 - BYTE_W * k -: BYTE_W])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm     <= IDLE;
      data_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (fsm)
        IDLE: begin
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          if (bus.start_i) begin
            data_q  <= sub_all;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
            fsm     <= RUN;
          end
        end
        RUN: begin
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          fsm     <= IDLE;
        end
      endcase
    end
  end

`else

  logic [AES_STATE_W-1:0] state_reg;
  logic                   mode;
  logic [1:0]             cnt;
  logic [COL_W-1:0]       col_in;
  logic [COL_W-1:0]       col_out;

  always_comb begin
    col_in = state_reg[127:96];
    unique case (cnt)
      2'd0: col_in = state_reg[127:96];
      2'd1: col_in = state_reg[95:64];
      2'd2: col_in = state_reg[63:32];
      2'd3: col_in = state_reg[31:0];
    endcase
  end

  for (genvar b = 0; b < NB; b++) begin : g_lane
    aes_sbox u_sbox (
      .in_byte  (col_in[COL_W - 1 - BYTE_W * b -: BYTE_W]),
      .inv      (mode),
      .out_byte (col_out[COL_W - 1 - BYTE_W * b -: BYTE_W])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      state_reg <= '0;
      mode      <= 1'b0;
      cnt       <= '0;
      data_q    <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      unique case (fsm)
        IDLE: begin
          if (bus.start_i) begin
            state_reg <= shifted;
            mode      <= bus.decrypt_i;
            cnt       <= '0;
            busy_q    <= 1'b1;
            fsm       <= RUN;
          end
        end
        RUN: begin
          unique case (cnt)
            2'd0: data_q[127:96] <= col_out;
            2'd1: data_q[95:64]  <= col_out;
            2'd2: data_q[63:32]  <= col_out;
            2'd3: data_q[31:0]   <= col_out;
          endcase
          if (cnt == 2'd3) begin
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            cnt     <= '0;
            fsm     <= IDLE;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
      endcase
    end
  end

`endif

  assign bus.data_o  = data_q;
  assign bus.ready_o = ready_q;
  assign bus.busy_o  = busy_q;

endmodule
